// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Command-word layout and opcodes shared by the SPI-slave byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int CMD_W = 10;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
// Module   : ram
// Purpose  : Single-port byte RAM behind the SPI slave. Decodes 10-bit command
//            words into address/data writes and registered reads.
//            Build option: define RAM_WR_ACK_EN to echo WR_DATA payloads on
//            dout with a one-cycle tx_valid acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module ram
  import ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] din,
  input  logic             rx_valid,
  output logic [7:0]       dout,
  output logic             tx_valid
);

  localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [7:0] mem [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;

  cmd_e                 w_cmd;
  logic [7:0]           w_payload;
  logic [c_IDX_W-1:0]   w_wr_idx;
  logic [c_IDX_W-1:0]   w_rd_idx;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_mem_we;
  logic [7:0]           w_rd_data;

  assign w_cmd     = cmd_e'(din[CMD_W-1 -: 2]);
  assign w_payload = din[7:0];
  assign w_wr_idx  = c_IDX_W'(wr_addr_q);
  assign w_rd_idx  = c_IDX_W'(rd_addr_q);

  // Range checks only exist when the address space exceeds the array.
  generate
    if (MEM_DEPTH >= (1 << ADDR_SIZE)) begin : g_full_map
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = 1'b1;
    end else begin : g_partial_map
      assign w_wr_in_range = (int'(wr_addr_q) < MEM_DEPTH);
      assign w_rd_in_range = (int'(rd_addr_q) < MEM_DEPTH);
    end
  endgenerate

  assign w_rd_data = w_rd_in_range ? mem[w_rd_idx] : 8'h00;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    w_mem_we   = 1'b0;
    if (rx_valid) begin
      case (w_cmd)
        CMD_WR_ADDR: wr_addr_d = ADDR_SIZE'(w_payload);
        CMD_WR_DATA: begin
          w_mem_we = w_wr_in_range;
`ifdef RAM_WR_ACK_EN
          dout_d     = w_payload;
          tx_valid_d = 1'b1;
`endif
        end
        CMD_RD_ADDR: rd_addr_d = ADDR_SIZE'(w_payload);
        CMD_RD_DATA: begin
          dout_d     = w_rd_data;
          tx_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_wr_idx] <= w_payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram
// Purpose  : Self-checking bench for ram: vector table plus scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram;
  import ram_pkg::*;

`ifdef RAM_WR_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [CMD_W-1:0] din;
  logic             rx_valid;
  logic [7:0]       dout;
  logic             tx_valid;

  ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rxv;
    logic [1:0] op;
    logic [7:0] data;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic       exp_tx;
    string      name;
  } vec_t;

  typedef struct {
    logic       chk_dout;
    logic [7:0] dout;
    logic       tx;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [7:0] pat(input int i);
    logic [7:0] v;
    v = 8'(i);
    return v ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rxv, input logic [1:0] op, input logic [7:0] data,
                     input logic chk_dout, input logic [7:0] exp_dout,
                     input logic exp_tx, input string name);
    vec_t v;
    v.rxv = rxv; v.op = op; v.data = data; v.chk_dout = chk_dout;
    v.exp_dout = exp_dout; v.exp_tx = exp_tx; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one command, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rx_valid = v.rxv;
    din      = {v.op, v.data};
    e.chk_dout = v.chk_dout;
    e.dout     = v.exp_dout;
    e.tx       = v.exp_tx;
    e.name     = v.name;
    if (ACK && v.rxv && v.op == 2'b01) begin
      e.chk_dout = 1'b1;
      e.dout     = v.data;
      e.tx       = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, "_tx"}, {7'd0, tx_valid}, {7'd0, got.tx});
    if (got.chk_dout) chk({got.name, "_dout"}, dout, got.dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    din      = 10'b11_0000_0000;
    for (int i = 0; i < 256; i++) dut.mem[i] = pat(i);

    // Reset held with a live RD_DATA on the bus.
    #1;
    chk("rst_t0_dout", dout, 8'h00);
    chk("rst_t0_tx", {7'd0, tx_valid}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_dout", dout, 8'h00);
      chk("rst_hold_tx", {7'd0, tx_valid}, 8'h00);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;

    add(1, 2'b00, 8'h00, 0, 8'h00, 0, "rt_wraddr");
    add(1, 2'b01, 8'hFF, 0, 8'h00, 0, "rt_wrdata");
    add(1, 2'b10, 8'h00, 0, 8'h00, 0, "rt_rdaddr");
    add(1, 2'b11, 8'h00, 1, 8'hFF, 1, "rt_rddata");
    add(0, 2'b00, 8'h00, 1, 8'hFF, 0, "rt_idle");
    add(1, 2'b10, 8'h05, 0, 8'h00, 0, "pre_rdaddr");
    add(1, 2'b11, 8'h00, 1, pat(5), 1, "pre_rddata");
    add(0, 2'b11, 8'h00, 1, pat(5), 0, "pre_idle");
    add(0, 2'b00, 8'h10, 0, 8'h00, 0, "gate_wraddr");
    add(0, 2'b01, 8'hA5, 0, 8'h00, 0, "gate_wrdata");
    add(1, 2'b10, 8'h10, 0, 8'h00, 0, "gate_rdaddr");
    add(1, 2'b11, 8'h99, 1, pat(16), 1, "gate_rddata");
    add(1, 2'b00, 8'h20, 0, 8'h00, 0, "ind_wraddr");
    add(1, 2'b10, 8'h30, 0, 8'h00, 0, "ind_rdaddr");
    add(1, 2'b01, 8'h3C, 0, 8'h00, 0, "ind_wrdata");
    add(1, 2'b11, 8'h00, 1, pat(48), 1, "ind_rd30");
    add(1, 2'b10, 8'h20, 0, 8'h00, 0, "ind_rdaddr20");
    add(1, 2'b11, 8'h00, 1, 8'h3C, 1, "ind_rd20");
    add(1, 2'b11, 8'h00, 1, 8'h3C, 1, "b2b_rd20");
    add(1, 2'b10, 8'h41, 0, 8'h00, 0, "wtr_rdaddr");
    add(1, 2'b00, 8'h41, 0, 8'h00, 0, "wtr_wraddr");
    add(1, 2'b01, 8'h66, 0, 8'h00, 0, "wtr_wrdata");
    add(1, 2'b11, 8'h00, 1, 8'h66, 1, "wtr_rddata");
    add(0, 2'b11, 8'h00, 1, 8'h66, 0, "wtr_idle");
    add(1, 2'b00, 8'hFF, 0, 8'h00, 0, "top_wraddr");
    add(1, 2'b01, 8'hC3, 0, 8'h00, 0, "top_wrdata");
    add(1, 2'b10, 8'hFF, 0, 8'h00, 0, "top_rdaddr");
    add(1, 2'b11, 8'h00, 1, 8'hC3, 1, "top_rddata");
    add(1, 2'b10, 8'h07, 0, 8'h00, 0, "mid_rdaddr");
    add(1, 2'b11, 8'h00, 1, pat(7), 1, "mid_rddata");

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply(v);
    end

    // Asynchronous reset mid-pulse: outputs must clear before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_tx", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;

    // rd_addr was cleared, so this reads address 0 (written 8'hFF earlier).
    v.rxv = 1; v.op = 2'b11; v.data = 8'h07; v.chk_dout = 1;
    v.exp_dout = 8'hFF; v.exp_tx = 1; v.name = "post_rst_rd0";
    apply(v);
    v.rxv = 0; v.exp_tx = 0; v.name = "post_rst_idle";
    apply(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
